// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with valid/ready handshake, two-entry skid buffer and WB snoop
module id_ex_skid_reg #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH         = 16,
    parameter int WB_SNOOP           = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic [REG_DATA_WIDTH-1:0]     In_PC,
    input  logic [REG_DATA_WIDTH-1:0]     In_PC_dest,
    input  logic [REG_DATA_WIDTH-1:0]     In_Imm1,
    input  logic [REG_DATA_WIDTH-1:0]     In_Imm2,
    input  logic [REG_DATA_WIDTH-1:0]     In_Rs1_data,
    input  logic [REG_DATA_WIDTH-1:0]     In_Rs2_data,
    input  logic [CTRL_WIDTH-1:0]         In_Ctrl,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_Rd_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_Rs2_addr,
    input  logic                          Flush,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WB_Rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]     WB_Rd_data,
    input  logic                          WB_RegFile_wr_en,
    output logic                          Out_valid,
    input  logic                          Out_ready,
    output logic [REG_DATA_WIDTH-1:0]     Out_PC,
    output logic [REG_DATA_WIDTH-1:0]     Out_PC_dest,
    output logic [REG_DATA_WIDTH-1:0]     Out_Imm1,
    output logic [REG_DATA_WIDTH-1:0]     Out_Imm2,
    output logic [REG_DATA_WIDTH-1:0]     Out_Rs1_data,
    output logic [REG_DATA_WIDTH-1:0]     Out_Rs2_data,
    output logic [CTRL_WIDTH-1:0]         Out_Ctrl,
    output logic [REGFILE_ADDR_WIDTH-1:0] Out_Rd_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0] Out_Rs1_addr,
    output logic [REGFILE_ADDR_WIDTH-1:0] Out_Rs2_addr,
    output logic [1:0]                    Out_Occupancy
);

    typedef struct packed {
        logic [REG_DATA_WIDTH-1:0]     pc;
        logic [REG_DATA_WIDTH-1:0]     pc_dest;
        logic [REG_DATA_WIDTH-1:0]     imm1;
        logic [REG_DATA_WIDTH-1:0]     imm2;
        logic [REG_DATA_WIDTH-1:0]     rs1_data;
        logic [REG_DATA_WIDTH-1:0]     rs2_data;
        logic [CTRL_WIDTH-1:0]         ctrl;
        logic [REGFILE_ADDR_WIDTH-1:0] rd_addr;
        logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr;
        logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_e;
    logic   m_valid_q, m_valid_d;
    logic   s_valid_q, s_valid_d;
    logic   ready_q;
    logic   [1:0] occ_q;
    logic   accept;
    logic   pop;

    // Replace Rs data with the WB value when the entry reads the register being written.
    function automatic entry_t snoop(
        input entry_t                          e,
        input logic                            wb_en,
        input logic [REGFILE_ADDR_WIDTH-1:0]   wb_addr,
        input logic [REG_DATA_WIDTH-1:0]       wb_data
    );
        entry_t r;
        logic   live;
        r    = e;
        live = (WB_SNOOP != 0) && wb_en && (wb_addr != '0);
        if (live && (e.rs1_addr == wb_addr)) r.rs1_data = wb_data;
        if (live && (e.rs2_addr == wb_addr)) r.rs2_data = wb_data;
        return r;
    endfunction

    always_comb begin
        in_e.pc       = In_PC;
        in_e.pc_dest  = In_PC_dest;
        in_e.imm1     = In_Imm1;
        in_e.imm2     = In_Imm2;
        in_e.rs1_data = In_Rs1_data;
        in_e.rs2_data = In_Rs2_data;
        in_e.ctrl     = In_Ctrl;
        in_e.rd_addr  = In_Rd_addr;
        in_e.rs1_addr = In_Rs1_addr;
        in_e.rs2_addr = In_Rs2_addr;
    end

    assign accept = In_valid & In_ready;
    assign pop    = m_valid_q & Out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (m_valid_q) m_d = snoop(m_q, WB_RegFile_wr_en, WB_Rd_addr, WB_Rd_data);
        if (s_valid_q) s_d = snoop(s_q, WB_RegFile_wr_en, WB_Rd_addr, WB_Rd_data);

        if (pop) begin
            if (s_valid_q) begin
                m_d       = snoop(s_q, WB_RegFile_wr_en, WB_Rd_addr, WB_Rd_data);
                s_valid_d = 1'b0;
                s_d.ctrl  = '0;
            end else if (accept) begin
                m_d = snoop(in_e, WB_RegFile_wr_en, WB_Rd_addr, WB_Rd_data);
            end else begin
                m_valid_d = 1'b0;
                m_d.ctrl  = '0;
            end
        end else if (m_valid_q) begin
            // M stalled: the one word already in flight lands in the skid entry.
            if (accept) begin
                s_d       = snoop(in_e, WB_RegFile_wr_en, WB_Rd_addr, WB_Rd_data);
                s_valid_d = 1'b1;
            end
        end else if (accept) begin
            m_d       = snoop(in_e, WB_RegFile_wr_en, WB_Rd_addr, WB_Rd_data);
            m_valid_d = 1'b1;
        end

        // Flush keeps the stale payload visible but kills validity and control.
        if (Flush) begin
            m_d       = m_q;
            s_d       = s_q;
            m_d.ctrl  = '0;
            s_d.ctrl  = '0;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            occ_q     <= 2'd0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            ready_q   <= ~s_valid_d;
            occ_q     <= {1'b0, m_valid_d} + {1'b0, s_valid_d};
        end
    end

    // Reset gates the registered ready so nothing is offered in while reset is held.
    assign In_ready      = ready_q & ~Reset;
    assign Out_valid     = m_valid_q;
    assign Out_PC        = m_q.pc;
    assign Out_PC_dest   = m_q.pc_dest;
    assign Out_Imm1      = m_q.imm1;
    assign Out_Imm2      = m_q.imm2;
    assign Out_Rs1_data  = m_q.rs1_data;
    assign Out_Rs2_data  = m_q.rs2_data;
    assign Out_Ctrl      = m_q.ctrl;
    assign Out_Rd_addr   = m_q.rd_addr;
    assign Out_Rs1_addr  = m_q.rs1_addr;
    assign Out_Rs2_addr  = m_q.rs2_addr;
    assign Out_Occupancy = occ_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - directed vector bench for id_ex_skid_reg
module tb_id_ex_skid_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_valid;
    logic [31:0] In_PC, In_PC_dest, In_Imm1, In_Imm2, In_Rs1_data, In_Rs2_data;
    logic [15:0] In_Ctrl;
    logic [4:0]  In_Rd_addr, In_Rs1_addr, In_Rs2_addr;
    logic        Flush;
    logic [4:0]  WB_Rd_addr;
    logic [31:0] WB_Rd_data;
    logic        WB_RegFile_wr_en;
    logic        Out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_pc, a_pc_dest, a_imm1, a_imm2, a_rs1_data, a_rs2_data;
    logic [15:0] a_ctrl;
    logic [4:0]  a_rd_addr, a_rs1_addr, a_rs2_addr;
    logic [1:0]  a_occ;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_pc, b_pc_dest, b_imm1, b_imm2, b_rs1_data, b_rs2_data;
    logic [15:0] b_ctrl;
    logic [4:0]  b_rd_addr, b_rs1_addr, b_rs2_addr;
    logic [1:0]  b_occ;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    id_ex_skid_reg #(.WB_SNOOP(1)) dut_snoop (
        .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_ready(a_in_ready),
        .In_PC(In_PC), .In_PC_dest(In_PC_dest), .In_Imm1(In_Imm1), .In_Imm2(In_Imm2),
        .In_Rs1_data(In_Rs1_data), .In_Rs2_data(In_Rs2_data), .In_Ctrl(In_Ctrl),
        .In_Rd_addr(In_Rd_addr), .In_Rs1_addr(In_Rs1_addr), .In_Rs2_addr(In_Rs2_addr),
        .Flush(Flush), .WB_Rd_addr(WB_Rd_addr), .WB_Rd_data(WB_Rd_data),
        .WB_RegFile_wr_en(WB_RegFile_wr_en), .Out_valid(a_out_valid), .Out_ready(Out_ready),
        .Out_PC(a_pc), .Out_PC_dest(a_pc_dest), .Out_Imm1(a_imm1), .Out_Imm2(a_imm2),
        .Out_Rs1_data(a_rs1_data), .Out_Rs2_data(a_rs2_data), .Out_Ctrl(a_ctrl),
        .Out_Rd_addr(a_rd_addr), .Out_Rs1_addr(a_rs1_addr), .Out_Rs2_addr(a_rs2_addr),
        .Out_Occupancy(a_occ)
    );

    id_ex_skid_reg #(.WB_SNOOP(0)) dut_plain (
        .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_ready(b_in_ready),
        .In_PC(In_PC), .In_PC_dest(In_PC_dest), .In_Imm1(In_Imm1), .In_Imm2(In_Imm2),
        .In_Rs1_data(In_Rs1_data), .In_Rs2_data(In_Rs2_data), .In_Ctrl(In_Ctrl),
        .In_Rd_addr(In_Rd_addr), .In_Rs1_addr(In_Rs1_addr), .In_Rs2_addr(In_Rs2_addr),
        .Flush(Flush), .WB_Rd_addr(WB_Rd_addr), .WB_Rd_data(WB_Rd_data),
        .WB_RegFile_wr_en(WB_RegFile_wr_en), .Out_valid(b_out_valid), .Out_ready(Out_ready),
        .Out_PC(b_pc), .Out_PC_dest(b_pc_dest), .Out_Imm1(b_imm1), .Out_Imm2(b_imm2),
        .Out_Rs1_data(b_rs1_data), .Out_Rs2_data(b_rs2_data), .Out_Ctrl(b_ctrl),
        .Out_Rd_addr(b_rd_addr), .Out_Rs1_addr(b_rs1_addr), .Out_Rs2_addr(b_rs2_addr),
        .Out_Occupancy(b_occ)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_rdy;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
        return {8'hA5, pc[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_fields"}, {31'd0, |{a_out_valid, a_pc, a_pc_dest, a_imm1, a_imm2, a_rs1_data,
            a_rs2_data, a_ctrl, a_rd_addr, a_rs1_addr, a_rs2_addr, a_occ}}, 32'd0);
        chk({tag, "_b_fields"}, {31'd0, |{b_out_valid, b_pc, b_pc_dest, b_imm1, b_imm2, b_rs1_data,
            b_rs2_data, b_ctrl, b_rd_addr, b_rs1_addr, b_rs2_addr, b_occ}}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; In_valid = 1'b0; Flush = 1'b0; Out_ready = 1'b0;
        In_PC = '0; In_PC_dest = '0; In_Imm1 = '0; In_Imm2 = '0;
        In_Rs1_data = 32'h11; In_Rs2_data = 32'h22; In_Ctrl = '0;
        In_Rd_addr = 5'd9; In_Rs1_addr = 5'd1; In_Rs2_addr = 5'd2;
        WB_Rd_addr = '0; WB_Rd_data = '0; WB_RegFile_wr_en = 1'b0;

        vecs[0]  = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 32'hFC, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 2'd1};
        vecs[8]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 32'hFC, 1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 2'd0};
        vecs[10] = '{1'b1, 32'h1C, 1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h1C, 1'b0, 2'd2};
        vecs[12] = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 32'hFC, 1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 2'd0};
        vecs[14] = '{1'b1, 32'h28, 1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 2'd0};
        vecs[15] = '{1'b0, 32'hFC, 1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 2'd0};

        // reset: ready low while reset held, all outputs zero, ready high once released
        tick();
        chk("rst_in_ready_held", {31'd0, a_in_ready}, 32'd0);
        chk_all_zero("rst");
        Reset = 1'b0;
        #1;
        chk("rst_in_ready_after", {31'd0, a_in_ready}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            In_valid  = vecs[i].v;
            In_PC     = vecs[i].pc;
            In_Ctrl   = ctrl_of(vecs[i].pc);
            In_Imm1   = vecs[i].pc ^ 32'hFFFF;
            Out_ready = vecs[i].ordy;
            Flush     = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, a_out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i), a_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_imm1", i), a_imm1, vecs[i].e_pc ^ 32'hFFFF);
            chk($sformatf("v%0d_in_ready", i), {31'd0, a_in_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_occ", i), {30'd0, a_occ}, {30'd0, vecs[i].e_occ});
            chk($sformatf("v%0d_ctrl", i), {16'd0, a_ctrl},
                vecs[i].e_valid ? {16'd0, ctrl_of(vecs[i].e_pc)} : 32'd0);
        end
        Flush = 1'b0;

        // capture bypass: same-edge WB write to the incoming Rs2
        In_valid = 1'b1; Out_ready = 1'b0; In_PC = 32'h40; In_Ctrl = ctrl_of(32'h40);
        In_Rs2_addr = 5'd7; In_Rs2_data = 32'hAAAA;
        WB_RegFile_wr_en = 1'b1; WB_Rd_addr = 5'd7; WB_Rd_data = 32'h5555;
        tick();
        chk("bypass_snoop_rs2", a_rs2_data, 32'h5555);
        chk("bypass_plain_rs2", b_rs2_data, 32'hAAAA);
        In_valid = 1'b0; WB_RegFile_wr_en = 1'b0; Out_ready = 1'b1;
        tick();

        // held M snoop on both Rs fields
        In_valid = 1'b1; Out_ready = 1'b0; In_PC = 32'h44;
        In_Rs1_addr = 5'd5; In_Rs2_addr = 5'd5; In_Rs1_data = 32'h1111; In_Rs2_data = 32'h1111;
        tick();
        In_valid = 1'b0;
        WB_RegFile_wr_en = 1'b1; WB_Rd_addr = 5'd5; WB_Rd_data = 32'hDEAD;
        tick();
        chk("held_snoop_rs1", a_rs1_data, 32'hDEAD);
        chk("held_snoop_rs2", a_rs2_data, 32'hDEAD);
        chk("held_plain_rs1", b_rs1_data, 32'h1111);
        WB_RegFile_wr_en = 1'b0; Flush = 1'b1;
        tick();
        Flush = 1'b0;

        // x0 never snoops
        In_valid = 1'b1; In_Rs1_addr = 5'd0; In_Rs2_addr = 5'd6;
        In_Rs1_data = 32'h2222; In_Rs2_data = 32'h3333;
        tick();
        In_valid = 1'b0;
        WB_RegFile_wr_en = 1'b1; WB_Rd_addr = 5'd0; WB_Rd_data = 32'hBEEF;
        tick();
        chk("x0_rs1_unchanged", a_rs1_data, 32'h2222);
        chk("x0_rs2_unchanged", a_rs2_data, 32'h3333);
        WB_RegFile_wr_en = 1'b0; Flush = 1'b1;
        tick();
        Flush = 1'b0;

        // both M and S snoop, then S moves to M carrying the updated data
        In_valid = 1'b1; In_Rs1_addr = 5'd3; In_Rs2_addr = 5'd4;
        In_PC = 32'h50; In_Rs1_data = 32'hA0;
        tick();
        In_PC = 32'h54; In_Rs1_data = 32'hB0;
        tick();
        chk("ms_occ_full", {30'd0, a_occ}, 32'd2);
        In_valid = 1'b0;
        WB_RegFile_wr_en = 1'b1; WB_Rd_addr = 5'd3; WB_Rd_data = 32'hC0;
        tick();
        chk("ms_m_snoop", a_rs1_data, 32'hC0);
        WB_RegFile_wr_en = 1'b0; Out_ready = 1'b1;
        tick();
        chk("ms_pop_pc", a_pc, 32'h54);
        chk("ms_s_snoop", a_rs1_data, 32'hC0);
        chk("ms_plain_s", b_rs1_data, 32'hB0);
        chk("ms_pop_ready", {31'd0, a_in_ready}, 32'd1);

        // reset mid-stream with both entries held
        In_valid = 1'b1; Out_ready = 1'b0; In_PC = 32'h58;
        tick();
        chk("mid_occ_full", {30'd0, a_occ}, 32'd2);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ready_low", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk_all_zero("mid_rst");
        Reset = 1'b0; In_valid = 1'b0;
        #1;
        chk("mid_rst_ready_high", {31'd0, a_in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
